dds_note_gen: RTL and testbench

- Per-note direct digital synthesis voice for the piano sound path. One instance per key.
- A 25-bit phase accumulator steps by a frequency control word scaled by the selected octave.
- The top 11 phase bits address an internal 2048-point sine table that produces a 12-bit unsigned sample.
- The speaker mixer consumes the phase (`count`) and/or the sample (`sin_out`). Frequency resolution is 48 MHz / 2^25 ≈ 1.43 Hz per fcw LSB.

---
 rtl/dds_note_gen.sv | 121 ++++++++++++
 tb/tb_dds_note_gen.sv | 122 ++++++++++++
 2 files changed

// File: rtl/dds_note_gen.sv
// Per-key DDS voice: octave-scaled phase accumulator feeding a 2048-point sine table.
// Define DDS_QUARTER_WAVE_EN to store one quadrant and rebuild the wave by symmetry.
module dds_note_gen #(
    parameter int ACC_W  = 25,
    parameter int ADDR_W = 11,
    parameter int DATA_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              key_n,
    input  logic [2:0]        yinjie,
    input  logic [2:0]        yinjie_box,
    input  logic              stat,
    input  logic [15:0]       fcw,
    input  logic              sin_en,
    output logic [ACC_W-1:0]  count,
    output logic [DATA_W-1:0] sin_out
);

    localparam int FULL  = 1 << ADDR_W;
    localparam int QUART = FULL / 4;
    localparam int QA_W  = ADDR_W - 2;
    localparam int MID   = 1 << (DATA_W - 1);
    localparam int AMP   = MID - 1;
    localparam longint PI_Q40 = 64'sd3454217652358;

    // Elaboration-time sine in Q30 fixed point (Taylor series on a first-quadrant angle),
    // so the table needs no external init file.
    function automatic logic [DATA_W-1:0] sine_entry(input int a);
        longint k;
        longint x;
        longint x2;
        longint term;
        longint s;
        longint mag;
        int     r;
        r = a % QUART;
        k = (((a / QUART) % 2) == 1) ? longint'(QUART - r) : longint'(r);
        x = ((k * PI_Q40) / longint'(2 * QUART)) >>> 10;
        x2 = (x * x) >>> 30;
        term = x;
        s = x;
        for (int n = 1; n <= 8; n++) begin
            term = -(((term * x2) >>> 30) / longint'((2 * n) * (2 * n + 1)));
            s = s + term;
        end
        mag = (s * longint'(AMP) + (longint'(1) <<< 29)) >>> 30;
        if (a >= 2 * QUART)
            return DATA_W'(longint'(MID) - mag);
        else
            return DATA_W'(longint'(MID) + mag);
    endfunction

    logic [ACC_W-1:0]  count_q, count_d;
    logic [DATA_W-1:0] sin_out_q, sin_out_d;
    logic [2:0]        oct;
    logic [2:0]        sh;
    logic [ACC_W-1:0]  step;
    logic              run;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] table_val;

    assign addr = count_q[ACC_W-1 -: ADDR_W];

`ifdef DDS_QUARTER_WAVE_EN
    logic [DATA_W-1:0] sine_rom [QUART];
    logic [QA_W-1:0]   q_lo, q_idx;
    logic              q_mirror, q_neg;
    logic [DATA_W-1:0] q_val;
    logic [DATA_W:0]   q_flip;

    for (genvar gi = 0; gi < QUART; gi++) begin : g_rom
        assign sine_rom[gi] = sine_entry(gi);
    end

    // Second/fourth quadrants mirror about the peak (QUART - lo); the peak itself
    // is outside the stored range and is supplied directly.
    always_comb begin
        q_lo     = addr[QA_W-1:0];
        q_mirror = addr[ADDR_W-2];
        q_neg    = addr[ADDR_W-1];
        q_idx    = q_mirror ? QA_W'(QUART - int'(q_lo)) : q_lo;
        q_val    = (q_mirror && (q_lo == '0)) ? DATA_W'(MID + AMP) : sine_rom[q_idx];
        q_flip   = (DATA_W + 1)'(2 * MID) - {1'b0, q_val};
        table_val = q_neg ? q_flip[DATA_W-1:0] : q_val;
    end
`else
    logic [DATA_W-1:0] sine_rom [FULL];

    for (genvar gi = 0; gi < FULL; gi++) begin : g_rom
        assign sine_rom[gi] = sine_entry(gi);
    end

    always_comb begin
        table_val = sine_rom[addr];
    end
`endif

    always_comb begin
        oct       = stat ? yinjie_box : yinjie;
        sh        = (oct == 3'd0) ? 3'd0 : oct - 3'd1;
        step      = {{(ACC_W-16){1'b0}}, fcw} << sh;
        run       = stat | ~key_n;
        count_d   = run ? count_q + step : '0;
        sin_out_d = sin_en ? table_val : sin_out_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q   <= '0;
            sin_out_q <= '0;
        end else begin
            count_q   <= count_d;
            sin_out_q <= sin_out_d;
        end
    end

    assign count   = count_q;
    assign sin_out = sin_out_q;

endmodule

// File: tb/tb_dds_note_gen.sv
// Directed bench for dds_note_gen: accumulation, octave switching, wrap, sine lookup, reset.
module tb_dds_note_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        key_n;
    logic [2:0]  yinjie;
    logic [2:0]  yinjie_box;
    logic        stat;
    logic [15:0] fcw;
    logic        sin_en;
    logic [24:0] count;
    logic [11:0] sin_out;

    int pass_cnt  = 0;
    int total_cnt = 0;

    dds_note_gen dut (
        .clk        (clk),
        .rst        (rst),
        .key_n      (key_n),
        .yinjie     (yinjie),
        .yinjie_box (yinjie_box),
        .stat       (stat),
        .fcw        (fcw),
        .sin_en     (sin_en),
        .count      (count),
        .sin_out    (sin_out)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) begin
            pass_cnt++;
            $display("ok   %s observed=%0d expected=%0d", tag, obs, exp);
        end else begin
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; key_n = 1'b1; stat = 1'b0; yinjie = 3'd1; yinjie_box = 3'd1;
        fcw = 16'd183; sin_en = 1'b0;
        tick(2);
        check("rst_count", 32'(count), 32'd0);
        check("rst_sin", 32'(sin_out), 32'd0);

        rst = 1'b0; key_n = 1'b0;
        tick(1); check("oct1_c1", 32'(count), 32'd183);
        tick(1); check("oct1_c2", 32'(count), 32'd366);
        tick(1); check("oct1_c3", 32'(count), 32'd549);

        key_n = 1'b1;
        tick(1); check("release", 32'(count), 32'd0);
        tick(1); check("release_hold", 32'(count), 32'd0);
        key_n = 1'b0;
        tick(1); check("repress", 32'(count), 32'd183);

        key_n = 1'b1; tick(1);
        yinjie = 3'd3; key_n = 1'b0;
        tick(1); check("oct3_c1", 32'(count), 32'd732);
        tick(1); check("oct3_c2", 32'(count), 32'd1464);
        tick(1); check("oct3_c3", 32'(count), 32'd2196);

        stat = 1'b1; yinjie_box = 3'd2; key_n = 1'b1;
        tick(1); check("song_oct2_c1", 32'(count), 32'd2562);
        tick(1); check("song_oct2_c2", 32'(count), 32'd2928);
        yinjie_box = 3'd0;
        tick(1); check("oct0_as_1", 32'(count), 32'd3111);

        stat = 1'b0; key_n = 1'b1; tick(1);
        fcw = 16'd65535; yinjie = 3'd7; key_n = 1'b0;
        tick(1); check("wrap_c1", 32'(count), 32'd4194240);
        tick(7); check("wrap_c8", 32'(count), 32'd33553920);
        tick(1); check("wrap_c9", 32'(count), 32'd4193728);

        key_n = 1'b1; tick(1);
        fcw = 16'd32768; key_n = 1'b0;
        tick(4); check("addr512_count", 32'(count), 32'd8388608);
        sin_en = 1'b1; key_n = 1'b1;
        tick(1);
        check("release_count", 32'(count), 32'd0);
        check("sin_addr512", 32'(sin_out), 32'd4095);
        tick(1); check("sin_addr0", 32'(sin_out), 32'd2048);

        sin_en = 1'b0; key_n = 1'b0;
        tick(12); check("addr1536_count", 32'(count), 32'd25165824);
        sin_en = 1'b1; key_n = 1'b1;
        tick(1); check("sin_addr1536", 32'(sin_out), 32'd1);

        sin_en = 1'b0; key_n = 1'b0;
        tick(1); check("sin_hold1", 32'(sin_out), 32'd1);
        tick(7);
        check("addr1024_count", 32'(count), 32'd16777216);
        check("sin_hold8", 32'(sin_out), 32'd1);
        sin_en = 1'b1;
        tick(1); check("sin_addr1024", 32'(sin_out), 32'd2048);
        tick(1); check("sin_addr1152", 32'(sin_out), 32'd1265);
        tick(1); check("sin_addr1280", 32'(sin_out), 32'd601);
        tick(1); check("sin_addr1408", 32'(sin_out), 32'd157);

        rst = 1'b1;
        tick(1);
        check("midrst_count", 32'(count), 32'd0);
        check("midrst_sin", 32'(sin_out), 32'd0);
        rst = 1'b0;
        tick(1);
        check("post_rst_count", 32'(count), 32'd2097152);
        check("post_rst_sin", 32'(sin_out), 32'd2048);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
